// File: rtl/alu_mc_unit_if.sv
// Request/response bus for alu_mc_unit: valid/ready request carrying opcode and
// operands, valid/ready response carrying the 32-bit result and error flag.
interface alu_mc_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  alu_op;
    logic [15:0] data_in1;
    logic [15:0] data_in2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] result;
    logic        rsp_err;
    logic        busy;

    modport slave (
        input  req_valid, alu_op, data_in1, data_in2, rsp_ready,
        output req_ready, rsp_valid, result, rsp_err, busy
    );

    modport master (
        output req_valid, alu_op, data_in1, data_in2, rsp_ready,
        input  req_ready, rsp_valid, result, rsp_err, busy
    );
endinterface

// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU responder: 1-cycle add/sub/and/or, 16-cycle shift-add MUL and
// restoring DIV. Define ALU_MC_DIV_EN to build the divider; otherwise op 101 is illegal.
module alu_mc_unit (
    input  logic          clk,
    input  logic          rst_n,
    alu_mc_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef ALU_MC_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] result_r;
    logic        err_r;
    logic        hs;
    logic [32:0] quick;
    logic [31:0] mul_pp;

    // Returns {err, result}; MUL and non-zero DIV start from a cleared accumulator.
    function automatic logic [32:0] quick_op(input logic [2:0] op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
        logic [16:0]        sum;
        logic signed [15:0] diff;
        sum  = {1'b0, a} + {1'b0, b};
        diff = signed'(a - b);
        case (op)
            3'b000:  quick_op = {1'b0, 15'd0, sum};
            3'b001:  quick_op = {1'b0, {16{diff[15]}}, diff};
            3'b010:  quick_op = {1'b0, 16'd0, a & b};
            3'b011:  quick_op = {1'b0, 16'd0, a | b};
            3'b100:  quick_op = 33'd0;
`ifdef ALU_MC_DIV_EN
            3'b101:  quick_op = (b == 16'd0) ? {1'b1, a, 16'hFFFF} : 33'd0;
`endif
            default: quick_op = {1'b1, 32'd0};
        endcase
    endfunction

    assign hs     = bus.req_valid & bus.req_ready;
    assign quick  = quick_op(bus.alu_op, bus.data_in1, bus.data_in2);
    assign mul_pp = op_b[cnt] ? ({16'd0, op_a} << cnt) : 32'd0;

`ifdef ALU_MC_DIV_EN
    logic [16:0] div_trial;
    logic [15:0] div_rem;
    logic        div_q;

    // Trial subtract of the shifted partial remainder; negative result restores.
    always_comb begin
        div_trial = {result_r[31:16], op_a[15]} - {1'b0, op_b};
        div_q     = ~div_trial[16];
        div_rem   = div_q ? div_trial[15:0] : {result_r[30:16], op_a[15]};
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs) begin
                    if (bus.alu_op == 3'b100)
                        state_nxt = MUL;
`ifdef ALU_MC_DIV_EN
                    else if (bus.alu_op == 3'b101 && bus.data_in2 != 16'd0)
                        state_nxt = DIV;
`endif
                    else
                        state_nxt = DONE;
                end
            end
            MUL: if (cnt == 4'd15) state_nxt = DONE;
`ifdef ALU_MC_DIV_EN
            DIV: if (cnt == 4'd15) state_nxt = DONE;
`endif
            DONE: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= 4'd0;
            result_r <= 32'd0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        cnt               <= 4'd0;
                        {err_r, result_r} <= quick;
                    end
                end
                MUL: begin
                    result_r <= result_r + mul_pp;
                    cnt      <= cnt + 4'd1;
                end
`ifdef ALU_MC_DIV_EN
                DIV: begin
                    result_r <= {div_rem, result_r[14:0], div_q};
                    cnt      <= cnt + 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Operands are captured only at the handshake; the dividend shifts out MSB-first.
    always_ff @(posedge clk) begin
        if (hs) begin
            op_a <= bus.data_in1;
            op_b <= bus.data_in2;
        end
`ifdef ALU_MC_DIV_EN
        else if (state == DIV) begin
            op_a <= {op_a[14:0], 1'b0};
        end
`endif
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_r;
    assign bus.rsp_err   = err_r;
endmodule
